instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage feeding InstructionMemoryModule and latching its output. Holds the PC,
//  drives instructionAddress, captures instruction into the IF/ID register (instr, pc,
//  valid) for decode. Handles pipeline stall, taken-branch redirect with squash, and halt/resume.
//  Instruction memory read is combinational: instruction is valid in the cycle the address is driven.
// PARAMETERS
//  ADDR_WIDTH  32             PC / address width
//  DATA_WIDTH  32             instruction width
//  RESET_PC    32'h0000_0000  PC value after reset
//  NOP_INSTR   32'h0000_0013  bubble instruction (addi x0,x0,0) inserted on squash/idle
//  PC_STEP     4              PC increment per sequential fetch
// PORTS
//  clk                 in   1           rising-edge clock
//  resetN              in   1           asynchronous, active-low reset
//  stall               in   1           hold PC and IF/ID register
//  branchTaken         in   1           redirect PC to branchTarget, squash current fetch
//  branchTarget        in   ADDR_WIDTH  redirect address; bits [1:0] forced to 0
//  haltReq             in   1           enter HALTED
//  resume              in   1           leave HALTED
//  instructionAddress  out  ADDR_WIDTH  current PC, to instruction memory
//  instruction         in   DATA_WIDTH  memory read data for instructionAddress
//  fetchedInstruction  out  DATA_WIDTH  IF/ID instruction
//  fetchedPc           out  ADDR_WIDTH  IF/ID PC of fetchedInstruction
//  fetchedValid        out  1           IF/ID contents are a real instruction
//  halted              out  1           high while in HALTED
// BEHAVIOUR
//  Reset (async, immediate, any state): pc=RESET_PC, instructionAddress=RESET_PC,
//   fetchedInstruction=NOP_INSTR, fetchedPc=RESET_PC, fetchedValid=0, halted=0, state=IDLE.
//  instructionAddress = pc register (no combinational path from inputs).
//  States: IDLE -> FETCH unconditionally after one clock; FETCH -> HALTED on haltReq;
//   HALTED -> FETCH on resume. IDLE: pc held, fetchedValid=0; all inputs ignored.
//  FETCH, per rising edge, priority branchTaken > haltReq > stall > normal:
//   - branchTaken: pc<=branchTarget&~3; IF/ID<={NOP_INSTR,pc,0}; overrides stall and haltReq
//     (haltReq in same cycle dropped; requester must reassert).
//   - haltReq: state<=HALTED; pc held; IF/ID<={NOP_INSTR,pc,0}; halted=1 next cycle.
//   - stall: pc and IF/ID hold all values (fetchedValid unchanged).
//   - normal: IF/ID<={instruction,pc,1}; pc<=pc+PC_STEP.
//  HALTED: pc held, fetchedValid=0; branchTaken and stall ignored. resume -> FETCH, halted=0 next
//   cycle, first fetch at held pc. resume and haltReq together in HALTED: stay HALTED.
//  Latency: instruction at address A appears on fetchedInstruction one cycle after
//   instructionAddress==A with no stall; branch costs one bubble (fetchedValid=0 one cycle).
//  Arithmetic: pc+PC_STEP modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 32'h0000_0000, no flag.
//  stall held indefinitely: outputs fully stable; no fetch lost or duplicated on release.
// TESTING
//  1 Reset release, mem[A]=A^32'hA5A5_A5A5 -> idle 1 cycle valid=0; then fetchedPc 0,4,8 each
//    cycle with matching instruction, fetchedValid=1.
//  2 stall high 3 cycles at pc=8 -> instructionAddress stays 8, IF/ID stays {mem[4],4,1};
//    release -> next fetchedPc=8, no skip/duplicate.
//  3 branchTaken with branchTarget=32'h103 while stall=1 -> next cycle fetchedValid=0,
//    fetchedInstruction=NOP_INSTR, instructionAddress=32'h100; following cycle fetchedPc=32'h100.
//  4 haltReq at pc=32'h20 -> halted=1, valid=0, pc held 5 cycles despite branchTaken;
//    resume -> fetchedPc=32'h20 one cycle after exiting HALTED.
//  5 RESET_PC=32'hFFFF_FFF8 -> fetchedPc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6 resetN asserted mid-branch -> outputs take reset values immediately, before next clk edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and registers
// the returned word into the IF/ID register, with stall, branch squash and halt/resume.
module instruction_fetch_unit #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0]   NOP_INSTR  = DATA_WIDTH'(32'h0000_0013),
  parameter int unsigned             PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  stall,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  haltReq,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] instructionAddress,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] fetchedInstruction,
  output logic [ADDR_WIDTH-1:0] fetchedPc,
  output logic                  fetchedValid,
  output logic                  halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next_seq;
  logic [ADDR_WIDTH-1:0] branch_aligned;

  assign pc_next_seq        = pc + ADDR_WIDTH'(PC_STEP);
  assign branch_aligned     = {branchTarget[ADDR_WIDTH-1:2], 2'b00};
  assign instructionAddress = pc;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      pc                 <= RESET_PC;
      fetchedInstruction <= NOP_INSTR;
      fetchedPc          <= RESET_PC;
      fetchedValid       <= 1'b0;
      halted             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state        <= FETCH;
          fetchedValid <= 1'b0;
        end
        FETCH: begin
          // Branch wins over halt and stall; a simultaneous halt request is dropped.
          if (branchTaken) begin
            pc                 <= branch_aligned;
            fetchedInstruction <= NOP_INSTR;
            fetchedPc          <= pc;
            fetchedValid       <= 1'b0;
          end else if (haltReq) begin
            state              <= HALTED;
            halted             <= 1'b1;
            fetchedInstruction <= NOP_INSTR;
            fetchedPc          <= pc;
            fetchedValid       <= 1'b0;
          end else if (!stall) begin
            fetchedInstruction <= instruction;
            fetchedPc          <= pc;
            fetchedValid       <= 1'b1;
            pc                 <= pc_next_seq;
          end
        end
        HALTED: begin
          fetchedValid <= 1'b0;
          if (resume && !haltReq) begin
            state  <= FETCH;
            halted <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          fetchedValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
